// File: rtl/ctrl_decode_pipe_if.sv
// D-stage decode, hazard-control and E-stage control bundle for ctrl_decode_pipe.
// The SystemE signal is present only when SYSTEM_DECODE_EN is defined.
interface ctrl_decode_pipe_if;
  logic [6:0] opD;
  logic       funct7b0D;
  logic       StallE;
  logic       FlushE;
  logic [2:0] ImmSrcD;
  logic       IllegalD;
  logic       RegWriteE;
  logic       MemWriteE;
  logic       ALUSrcE;
  logic       BranchE;
  logic       JumpE;
  logic       JumpALRE;
  logic       AuipcE;
  logic       MduOpE;
  logic       IllegalE;
  logic [1:0] ResultSrcE;
  logic [1:0] ALUOpE;
  logic       MduStall;
`ifdef SYSTEM_DECODE_EN
  logic       SystemE;

  modport master (
    input  opD, funct7b0D, StallE, FlushE,
    output ImmSrcD, IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
           JumpALRE, AuipcE, MduOpE, IllegalE, ResultSrcE, ALUOpE, MduStall, SystemE
  );

  modport slave (
    output opD, funct7b0D, StallE, FlushE,
    input  ImmSrcD, IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
           JumpALRE, AuipcE, MduOpE, IllegalE, ResultSrcE, ALUOpE, MduStall, SystemE
  );
`else
  modport master (
    input  opD, funct7b0D, StallE, FlushE,
    output ImmSrcD, IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
           JumpALRE, AuipcE, MduOpE, IllegalE, ResultSrcE, ALUOpE, MduStall
  );

  modport slave (
    output opD, funct7b0D, StallE, FlushE,
    input  ImmSrcD, IllegalD, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE,
           JumpALRE, AuipcE, MduOpE, IllegalE, ResultSrcE, ALUOpE, MduStall
  );
`endif
endinterface

// File: rtl/ctrl_decode_pipe.sv
// RV32 control decoder with D->E pipeline register and multi-cycle MDU hold FSM.
// Optional SYSTEM_DECODE_EN: ecall/ebreak/fence decode legal and drive SystemE.
module ctrl_decode_pipe #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input logic          clk,
  input logic          reset,
  ctrl_decode_pipe_if.master bus
);

  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
    logic       jump_alr;
    logic       auipc;
    logic       mdu_op;
    logic       illegal;
`ifdef SYSTEM_DECODE_EN
    logic       system;
`endif
  } ctrl_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic             MDU_MULTI = (MDU_LATENCY > 1);
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'((MDU_LATENCY > 1) ? (MDU_LATENCY - 2) : 0);

  ctrl_t            d_s;
  ctrl_t            e_r;
  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             mdu_stall_s;
  logic             hold_s;
  logic             load_s;

  // Opcode decode; every field not named by the table stays zero.
  always_comb begin
    d_s = '0;
    case (bus.opD)
      7'b0000011: begin
        d_s.reg_write  = 1'b1;
        d_s.alu_src    = 1'b1;
        d_s.result_src = 2'b01;
      end
      7'b0100011: begin
        d_s.imm_src   = 3'b001;
        d_s.alu_src   = 1'b1;
        d_s.mem_write = 1'b1;
      end
      7'b0110011: begin
        d_s.reg_write = 1'b1;
        d_s.alu_op    = 2'b10;
        d_s.mdu_op    = bus.funct7b0D;
      end
      7'b1100011: begin
        d_s.imm_src = 3'b010;
        d_s.branch  = 1'b1;
        d_s.alu_op  = 2'b01;
      end
      7'b0010011: begin
        d_s.reg_write = 1'b1;
        d_s.alu_src   = 1'b1;
        d_s.alu_op    = 2'b10;
      end
      7'b1101111: begin
        d_s.reg_write  = 1'b1;
        d_s.imm_src    = 3'b011;
        d_s.result_src = 2'b10;
        d_s.jump       = 1'b1;
      end
      7'b1100111: begin
        d_s.reg_write  = 1'b1;
        d_s.alu_src    = 1'b1;
        d_s.result_src = 2'b10;
        d_s.jump       = 1'b1;
        d_s.jump_alr   = 1'b1;
      end
      7'b0010111: begin
        d_s.reg_write  = 1'b1;
        d_s.imm_src    = 3'b100;
        d_s.result_src = 2'b11;
        d_s.auipc      = 1'b1;
      end
      7'b0110111: begin
        d_s.reg_write  = 1'b1;
        d_s.imm_src    = 3'b100;
        d_s.result_src = 2'b11;
      end
      7'b0000000: begin
        d_s = '0;
      end
`ifdef SYSTEM_DECODE_EN
      7'b1110011, 7'b0001111: begin
        d_s.system = 1'b1;
      end
`endif
      default: begin
        d_s.illegal = 1'b1;
      end
    endcase
  end

  assign mdu_stall_s = (state_r == BUSY);
  assign hold_s      = bus.StallE | mdu_stall_s;
  assign load_s      = ~hold_s & ~bus.FlushE;

  // E-stage bundle register: reset, then hold, then flush, then load.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_r <= '0;
    end else if (hold_s) begin
      e_r <= e_r;
    end else if (bus.FlushE) begin
      e_r <= '0;
    end else begin
      e_r <= d_s;
    end
  end

  // MDU hold state and countdown registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Hold runs for MDU_LATENCY-1 cycles after an M-op enters E; StallE does not pause it.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (MDU_MULTI && load_s && d_s.mdu_op) begin
          state_s = BUSY;
          cnt_s   = CNT_INIT;
        end else begin
          state_s = IDLE;
          cnt_s   = cnt_r;
        end
      end
      BUSY: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = IDLE;
          cnt_s   = cnt_r;
        end else begin
          state_s = BUSY;
          cnt_s   = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign bus.ImmSrcD    = d_s.imm_src;
  assign bus.IllegalD   = d_s.illegal;
  assign bus.RegWriteE  = e_r.reg_write;
  assign bus.MemWriteE  = e_r.mem_write;
  assign bus.ALUSrcE    = e_r.alu_src;
  assign bus.BranchE    = e_r.branch;
  assign bus.JumpE      = e_r.jump;
  assign bus.JumpALRE   = e_r.jump_alr;
  assign bus.AuipcE     = e_r.auipc;
  assign bus.MduOpE     = e_r.mdu_op;
  assign bus.IllegalE   = e_r.illegal;
  assign bus.ResultSrcE = e_r.result_src;
  assign bus.ALUOpE     = e_r.alu_op;
  assign bus.MduStall   = mdu_stall_s;
`ifdef SYSTEM_DECODE_EN
  assign bus.SystemE    = e_r.system;
`endif

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Randomized scoreboard bench for ctrl_decode_pipe against a table/occupancy reference model.
module tb_ctrl_decode_pipe;
  localparam int L = 4;

  typedef struct {
    logic [15:0] e;
    logic        stall;
    logic [3:0]  d;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  ctrl_decode_pipe_if bus();

  ctrl_decode_pipe #(.MDU_LATENCY(L), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  item_t       q[$];
  item_t       mon_it;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] m_e = '0;
  int          m_stall = 0;
  bit          m_known = 1'b0;
  logic [15:0] obs_e;
  logic [3:0]  obs_d;

  // {RegWrite,ImmSrc,ALUSrc,MemWrite,ResultSrc,Branch,ALUOp,Jump,JumpALR, Auipc, MduOp, Illegal}
  function automatic logic [15:0] ref_bundle(input logic [6:0] op, input logic f7);
    logic [12:0] t;
    logic a, m, il;
    t = '0; a = 1'b0; m = 1'b0; il = 1'b0;
    case (op)
      7'b0000011: t = 13'b1_000_1_0_01_0_00_0_0;
      7'b0100011: t = 13'b0_001_1_1_00_0_00_0_0;
      7'b0110011: begin t = 13'b1_000_0_0_00_0_10_0_0; m = f7; end
      7'b1100011: t = 13'b0_010_0_0_00_1_01_0_0;
      7'b0010011: t = 13'b1_000_1_0_00_0_10_0_0;
      7'b1101111: t = 13'b1_011_0_0_10_0_00_1_0;
      7'b1100111: t = 13'b1_000_1_0_10_0_00_1_1;
      7'b0010111: begin t = 13'b1_100_0_0_11_0_00_0_0; a = 1'b1; end
      7'b0110111: t = 13'b1_100_0_0_11_0_00_0_0;
      7'b0000000: t = '0;
`ifdef SYSTEM_DECODE_EN
      7'b1110011, 7'b0001111: t = '0;
`endif
      default: il = 1'b1;
    endcase
    return {t, a, m, il};
  endfunction

  task automatic step(input logic [6:0] op, input logic f7, input logic st,
                      input logic fl, input logic rs);
    logic [15:0] b;
    item_t it;
    reset = rs;
    bus.opD = op;
    bus.funct7b0D = f7;
    bus.StallE = st;
    bus.FlushE = fl;
    b = ref_bundle(op, f7);
    if (m_known) begin
      it.e = m_e;
      it.stall = (m_stall > 0);
      it.d = {b[14:12], b[0]};
      q.push_back(it);
    end
    if (rs) begin
      m_e = '0; m_stall = 0; m_known = 1'b1;
    end else if (st || m_stall > 0) begin
      if (m_stall > 0) m_stall = m_stall - 1;
    end else if (fl) begin
      m_e = '0;
    end else begin
      m_e = {b[15], 3'b000, b[11:0]};
      m_stall = b[1] ? L - 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_it = q.pop_front();
      obs_e = {bus.RegWriteE, 3'b000, bus.ALUSrcE, bus.MemWriteE, bus.ResultSrcE,
               bus.BranchE, bus.ALUOpE, bus.JumpE, bus.JumpALRE,
               bus.AuipcE, bus.MduOpE, bus.IllegalE};
      obs_d = {bus.ImmSrcD, bus.IllegalD};
      checks = checks + 3;
      if (obs_e !== mon_it.e) begin
        failures = failures + 1;
        $display("FAIL ebundle t=%0t got=%b want=%b", $time, obs_e, mon_it.e);
      end
      if (bus.MduStall !== mon_it.stall) begin
        failures = failures + 1;
        $display("FAIL mdustall t=%0t got=%b want=%b", $time, bus.MduStall, mon_it.stall);
      end
      if (obs_d !== mon_it.d) begin
        failures = failures + 1;
        $display("FAIL dcomb t=%0t got=%b want=%b", $time, obs_d, mon_it.d);
      end
    end
  end

  logic [6:0] ops [10];
  logic [6:0] rop;
  int         k;

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
            7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111, 7'b0000000};
    reset = 1'b1; bus.opD = '0; bus.funct7b0D = 1'b0; bus.StallE = 1'b0; bus.FlushE = 1'b0;
    @(posedge clk); #1;
    step(7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    step(7'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // table sweep, then an illegal opcode
    for (int i = 0; i < 10; i++) step(ops[i], 1'b0, 1'b0, 1'b0, 1'b0);
    step(7'b1111111, 1'b0, 1'b0, 1'b0, 1'b0);
    step(7'b0000011, 1'b0, 1'b0, 1'b0, 1'b0);
    // M-op hold, with following lw waiting in D
    step(7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(7'b0000011, 1'b0, 1'b0, 1'b0, 1'b0);
    // flush and stall during BUSY are ignored
    step(7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0);
    step(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0);
    step(7'b0100011, 1'b0, 1'b1, 1'b1, 1'b0);
    step(7'b0100011, 1'b0, 1'b0, 1'b1, 1'b0);
    step(7'b0100011, 1'b0, 1'b0, 1'b0, 1'b0);
    // flush in IDLE
    step(7'b1101111, 1'b0, 1'b0, 1'b1, 1'b0);
    step(7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
    // reset in second BUSY cycle, then lw
    step(7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0);
    step(7'b0000011, 1'b0, 1'b0, 1'b0, 1'b0);
    step(7'b0000011, 1'b0, 1'b0, 1'b0, 1'b1);
    step(7'b0000011, 1'b0, 1'b0, 1'b0, 1'b0);
    step(7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
    // StallE with sw in E and jal in D
    step(7'b0100011, 1'b0, 1'b0, 1'b0, 1'b0);
    step(7'b1101111, 1'b0, 1'b1, 1'b0, 1'b0);
    step(7'b1101111, 1'b0, 1'b1, 1'b0, 1'b0);
    step(7'b1101111, 1'b0, 1'b0, 1'b0, 1'b0);
    // back-to-back M-ops
    for (int i = 0; i < 10; i++) step(7'b0110011, 1'b1, 1'b0, 1'b0, 1'b0);
    step(7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      k = int'($urandom_range(0, 11));
      if (k < 10) rop = ops[k];
      else rop = 7'($urandom);
      step(rop, 1'($urandom), ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 2));
    end
    step(7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ctrl_decode_pipe.md
Name: ctrl_decode_pipe

Overview:
Next-generation control decoder for the pipelined RV32 core. It decodes the D-stage opcode into a fully specified control bundle with no X outputs, and flags illegal opcodes. It registers the bundle into the E stage with stall/flush handling. A small FSM holds E for multi-cycle M-extension (MUL/DIV) ops and raises a stall request to the hazard unit.

Parameters:
MDU_LATENCY, 4, cycles an M-ext op occupies E (1..16; 1 = no hold)
CNT_W, 4, width of MDU countdown counter (must hold MDU_LATENCY-1)

Ports:
clk  input  1  core clock
reset  input  1  synchronous, active-high reset
opD  input  7  instr[6:0] in D
funct7b0D  input  1  instr[25] in D (M-ext select for R-type)
StallE  input  1  hazard unit: hold E register
FlushE  input  1  hazard unit: load bubble into E
ImmSrcD  output  3  immediate format for D-stage extend unit (combinational)
IllegalD  output  1  opD not in decode table (combinational)
RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JumpALRE, AuipcE, MduOpE, IllegalE  output  1 each  registered E controls
ResultSrcE  output  2  00 ALU, 01 mem, 10 PC+4, 11 upper-imm
ALUOpE  output  2  00 add, 01 sub/branch, 10 funct-decoded
MduStall  output  1  E held by multi-cycle op; hazard unit stalls F/D/E

Behaviour:
- Decode table ({RegWrite,ImmSrc,ALUSrc,MemWrite,ResultSrc,Branch,ALUOp,Jump,JumpALR}), all don't-cares driven 0:
  - 0000011 lw: 1_000_1_0_01_0_00_0_0
  - 0100011 sw: 0_001_1_1_00_0_00_0_0
  - 0110011 R: 1_000_0_0_00_0_10_0_0; MduOp=funct7b0D
  - 1100011 B: 0_010_0_0_00_1_01_0_0
  - 0010011 I-ALU: 1_000_1_0_00_0_10_0_0
  - 1101111 jal: 1_011_0_0_10_0_00_1_0
  - 1100111 jalr: 1_000_1_0_10_0_00_1_1
  - 0010111 auipc: 1_100_0_0_11_0_00_0_0; Auipc=1
  - 0110111 lui: 1_100_0_0_11_0_00_0_0; Auipc=0
  - 0000000 bubble: all 0, legal
  - other: all 0, IllegalD=1
- Reset: all E outputs 0, FSM IDLE, counter 0, MduStall 0.
- E register update priority per cycle: reset > hold (StallE or MduStall) > FlushE (load all-zero bundle) > load decoded D bundle.
- FlushE while held: ignored; E keeps the in-flight op.
- FSM IDLE -> BUSY when MDU_LATENCY>1, MduOpE=1 and E was loaded this cycle. On entry the counter loads MDU_LATENCY-2.
- In BUSY, MduStall=1 combinationally. The counter decrements each cycle; count 0 -> IDLE (MduStall drops in that cycle).
- Op occupies E exactly MDU_LATENCY cycles.
- MDU_LATENCY=1: FSM stays IDLE, MduStall constant 0.
- Back-to-back M-ops: second loads on the cycle after release and restarts BUSY.
- StallE asserted in BUSY does not pause the counter.
- Reset mid-BUSY aborts: IDLE, bundle cleared, MduStall 0 next cycle.

Optional Feature:
SYSTEM_DECODE_EN: when defined, opcodes 1110011 (ecall/ebreak) and 0001111 (fence) decode as legal all-zero bundles and set an extra registered output SystemE=1. When undefined, the SystemE port does not exist and both opcodes decode as illegal (IllegalD=1).

Test Plan:
- Sweep all nine table opcodes plus 0000000 with no stall/flush -> E bundle equals table one cycle later; IllegalE=0; no X on any output.
- opD=1111111 -> IllegalD=1 same cycle; IllegalE=1 next cycle; RegWriteE=MemWriteE=0.
- opD=0110011, funct7b0D=1, MDU_LATENCY=4 -> MduOpE=1; MduStall high 3 cycles then low; E bundle unchanged throughout; next D op loads on the 4th-cycle edge.
- FlushE=1 during BUSY -> ignored, MduOpE stays 1. FlushE=1 in IDLE -> all E outputs 0 next cycle.
- Reset asserted in 2nd BUSY cycle -> next cycle MduStall=0, all E outputs 0, FSM IDLE. Then lw -> normal load.
- StallE=1 for 2 cycles with sw in E and jal in D -> E keeps sw bundle. On release, jal bundle (1_011_0_0_10_0_00_1_0) appears.
